mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester memory port arbiter. The fetch port and the memory-stage read/write ports share one
// downstream port. A request is latched at its grant edge and held on that port until the memory answers.
module mem_arbiter #(
   parameter int unsigned FETCH_STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req_valid_i,
   input  logic [31:0] if_req_addr_i,
   output logic        if_res_valid_o,
   output logic [31:0] if_res_data_o,
   input  logic        d_read_req_valid_i,
   input  logic [31:0] d_read_req_addr_i,
   output logic        d_read_res_valid_o,
   output logic [31:0] d_read_res_data_o,
   input  logic        d_write_req_valid_i,
   input  logic [31:0] d_write_req_addr_i,
   input  logic [31:0] d_write_req_data_i,
   input  logic [3:0]  d_write_req_mask_i,
   output logic        d_write_res_valid_o,
   output logic        mem_req_valid_o,
   output logic        mem_req_write_o,
   output logic [31:0] mem_req_addr_o,
   output logic [31:0] mem_req_wdata_o,
   output logic [3:0]  mem_req_mask_o,
   input  logic        mem_res_valid_i,
   input  logic [31:0] mem_res_rdata_i,
   output logic [1:0]  grant_o
);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mask;
      logic        write;
   } mreq_t;

   localparam logic [1:0] G_NONE = 2'd0;
   localparam logic [1:0] G_IF   = 2'd1;
   localparam logic [1:0] G_RD   = 2'd2;
   localparam logic [1:0] G_WR   = 2'd3;
   localparam logic [3:0] STARVE_MAX = 4'(FETCH_STARVE_MAX);

   state_t      state_q, state_d;
   logic [1:0]  owner_q, owner_d;
   mreq_t       req_q, req_d;
   logic [3:0]  starve_q, starve_d;
   logic [1:0]  win;
   logic        rsp;

   // A fetch that has waited out STARVE_MAX data grants overrides the fixed priority.
   always_comb begin
      win = G_NONE;
      if (if_req_valid_i && (starve_q == STARVE_MAX)) win = G_IF;
      else if (d_write_req_valid_i)                   win = G_WR;
      else if (d_read_req_valid_i)                    win = G_RD;
      else if (if_req_valid_i)                        win = G_IF;
   end

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      req_d    = req_q;
      starve_d = starve_q;
      case (state_q)
         S_IDLE: begin
            if (win != G_NONE) begin
               state_d = S_BUSY;
               owner_d = win;
               case (win)
                  G_WR: begin
                     req_d.addr  = d_write_req_addr_i;
                     req_d.wdata = d_write_req_data_i;
                     req_d.mask  = d_write_req_mask_i;
                     req_d.write = 1'b1;
                  end
                  G_RD: begin
                     req_d.addr  = d_read_req_addr_i;
                     req_d.wdata = '0;
                     req_d.mask  = 4'hF;
                     req_d.write = 1'b0;
                  end
                  default: begin
                     req_d.addr  = if_req_addr_i;
                     req_d.wdata = '0;
                     req_d.mask  = 4'hF;
                     req_d.write = 1'b0;
                  end
               endcase
               if ((win != G_IF) && if_req_valid_i)
                  starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 4'd1;
               else
                  starve_d = '0;
            end
         end
         S_BUSY: begin
            if (mem_res_valid_i) begin
               state_d = S_IDLE;
               owner_d = G_NONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         owner_q  <= G_NONE;
         req_q    <= '0;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         req_q    <= req_d;
         starve_q <= starve_d;
      end
   end

   assign mem_req_valid_o = (state_q == S_BUSY);
   assign mem_req_write_o = req_q.write;
   assign mem_req_addr_o  = req_q.addr;
   assign mem_req_wdata_o = req_q.wdata;
   assign mem_req_mask_o  = req_q.mask;
   assign grant_o         = owner_q;

   // A response outside BUSY is stray and must not reach any requester.
   assign rsp                 = (state_q == S_BUSY) && mem_res_valid_i;
   assign if_res_valid_o      = rsp && (owner_q == G_IF);
   assign d_read_res_valid_o  = rsp && (owner_q == G_RD);
   assign d_write_res_valid_o = rsp && (owner_q == G_WR);
   assign if_res_data_o       = mem_res_rdata_i;
   assign d_read_res_data_o   = mem_res_rdata_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then randomized traffic.
// A transaction-level reference model is compared against the DUT on every cycle.
module tb_mem_arbiter;
   localparam int MAX = 4;

   logic clk = 1'b0;
   logic rst;
   logic        if_req_valid, if_res_valid;
   logic [31:0] if_req_addr, if_res_data;
   logic        d_read_req_valid, d_read_res_valid;
   logic [31:0] d_read_req_addr, d_read_res_data;
   logic        d_write_req_valid, d_write_res_valid;
   logic [31:0] d_write_req_addr, d_write_req_data;
   logic [3:0]  d_write_req_mask;
   logic        mem_req_valid, mem_req_write;
   logic [31:0] mem_req_addr, mem_req_wdata;
   logic [3:0]  mem_req_mask;
   logic        mem_res_valid;
   logic [31:0] mem_res_rdata;
   logic [1:0]  grant;

   mem_arbiter #(.FETCH_STARVE_MAX(MAX)) dut (
      .clk(clk), .rst(rst),
      .if_req_valid_i(if_req_valid), .if_req_addr_i(if_req_addr),
      .if_res_valid_o(if_res_valid), .if_res_data_o(if_res_data),
      .d_read_req_valid_i(d_read_req_valid), .d_read_req_addr_i(d_read_req_addr),
      .d_read_res_valid_o(d_read_res_valid), .d_read_res_data_o(d_read_res_data),
      .d_write_req_valid_i(d_write_req_valid), .d_write_req_addr_i(d_write_req_addr),
      .d_write_req_data_i(d_write_req_data), .d_write_req_mask_i(d_write_req_mask),
      .d_write_res_valid_o(d_write_res_valid),
      .mem_req_valid_o(mem_req_valid), .mem_req_write_o(mem_req_write),
      .mem_req_addr_o(mem_req_addr), .mem_req_wdata_o(mem_req_wdata),
      .mem_req_mask_o(mem_req_mask),
      .mem_res_valid_i(mem_res_valid), .mem_res_rdata_i(mem_res_rdata),
      .grant_o(grant)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: one outstanding transaction, owner chosen by the priority rules.
   bit          m_busy;
   int          m_owner, m_starve, mw;
   logic [31:0] m_addr, m_wdata;
   logic [3:0]  m_mask;
   bit          m_write;

   always @(posedge clk) begin
      if (rst) begin
         m_busy = 0; m_owner = 0; m_starve = 0;
         m_addr = 0; m_wdata = 0; m_mask = 0; m_write = 0;
      end else if (m_busy) begin
         if (mem_res_valid) begin m_busy = 0; m_owner = 0; end
      end else begin
         mw = 0;
         if (if_req_valid && m_starve == MAX) mw = 1;
         else if (d_write_req_valid)          mw = 3;
         else if (d_read_req_valid)           mw = 2;
         else if (if_req_valid)               mw = 1;
         if (mw != 0) begin
            m_busy = 1; m_owner = mw;
            m_write = (mw == 3);
            m_addr  = (mw == 3) ? d_write_req_addr : (mw == 2) ? d_read_req_addr : if_req_addr;
            m_wdata = (mw == 3) ? d_write_req_data : 32'h0;
            m_mask  = (mw == 3) ? d_write_req_mask : 4'hF;
            if (mw != 1 && if_req_valid) m_starve = (m_starve < MAX) ? m_starve + 1 : MAX;
            else                         m_starve = 0;
         end
      end
   end

   // Per-cycle compare plus a log of each new grant for the directed checks.
   int gq[$], mq[$], aq[$], sq[$];
   int cnt[4];
   logic [1:0] prev_g = 2'd0;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("grant", 32'(grant), 32'(m_owner));
         chk("mem_req_valid", 32'(mem_req_valid), 32'(m_busy));
         if (m_busy) begin
            chk("mem_req_addr", mem_req_addr, m_addr);
            chk("mem_req_wdata", mem_req_wdata, m_wdata);
            chk("mem_req_mask", 32'(mem_req_mask), 32'(m_mask));
            chk("mem_req_write", 32'(mem_req_write), 32'(m_write));
         end
         chk("if_res_valid", 32'(if_res_valid), 32'(m_busy && mem_res_valid && m_owner == 1));
         chk("d_read_res_valid", 32'(d_read_res_valid), 32'(m_busy && mem_res_valid && m_owner == 2));
         chk("d_write_res_valid", 32'(d_write_res_valid), 32'(m_busy && mem_res_valid && m_owner == 3));
         if (if_res_valid)     chk("if_res_data", if_res_data, mem_res_rdata);
         if (d_read_res_valid) chk("d_read_res_data", d_read_res_data, mem_res_rdata);
         chk("starve", 32'(dut.starve_q), 32'(m_starve));
         if (grant != 2'd0 && prev_g == 2'd0) begin
            gq.push_back(int'(grant));
            mq.push_back(int'(mem_req_mask));
            aq.push_back(int'(mem_req_addr));
            sq.push_back(int'(dut.starve_q));
         end
         if (if_res_valid)      cnt[1]++;
         if (d_read_res_valid)  cnt[2]++;
         if (d_write_res_valid) cnt[3]++;
      end
      prev_g = grant;
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Requester/memory agents. ren: bitmask of requesters that always re-request after a response.
   task automatic run(input int n, input int p_new, input int p_ren, input int p_mem,
                      input int p_drop, input int p_rst, input int p_chg, input bit [3:0] ren);
      bit s1, s2, s3;
      logic [1:0] g;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         s1 = if_res_valid; s2 = d_read_res_valid; s3 = d_write_res_valid; g = grant;
         @(posedge clk); #1;
         rst = ($urandom_range(999) < p_rst);
         if (if_req_valid && s1) begin
            if_req_valid = ren[1] || ($urandom_range(99) < p_ren); if_req_addr = $urandom;
         end else if (!if_req_valid && $urandom_range(99) < p_new) begin
            if_req_valid = 1; if_req_addr = $urandom;
         end else if (if_req_valid && g == 2'd1 && $urandom_range(99) < p_drop) if_req_valid = 0;
         else if (g != 2'd1 && $urandom_range(99) < p_chg) if_req_addr = $urandom;
         if (d_read_req_valid && s2) begin
            d_read_req_valid = ren[2] || ($urandom_range(99) < p_ren); d_read_req_addr = $urandom;
         end else if (!d_read_req_valid && $urandom_range(99) < p_new) begin
            d_read_req_valid = 1; d_read_req_addr = $urandom;
         end else if (d_read_req_valid && g == 2'd2 && $urandom_range(99) < p_drop) d_read_req_valid = 0;
         else if (g != 2'd2 && $urandom_range(99) < p_chg) d_read_req_addr = $urandom;
         if (d_write_req_valid && s3) begin
            d_write_req_valid = ren[3] || ($urandom_range(99) < p_ren);
            d_write_req_addr = $urandom; d_write_req_data = $urandom; d_write_req_mask = 4'($urandom);
         end else if (!d_write_req_valid && $urandom_range(99) < p_new) begin
            d_write_req_valid = 1;
            d_write_req_addr = $urandom; d_write_req_data = $urandom; d_write_req_mask = 4'($urandom);
         end else if (d_write_req_valid && g == 2'd3 && $urandom_range(99) < p_drop) d_write_req_valid = 0;
         else if (g != 2'd3 && $urandom_range(99) < p_chg) begin
            d_write_req_addr = $urandom; d_write_req_data = $urandom; d_write_req_mask = 4'($urandom);
         end
         mem_res_valid = ($urandom_range(99) < p_mem);
         mem_res_rdata = $urandom;
      end
   endtask

   task automatic drain();
      bit ok = 0;
      for (int i = 0; i < 200; i++) begin
         run(1, 0, 0, 100, 0, 0, 0, 4'b0);
         if (!if_req_valid && !d_read_req_valid && !d_write_req_valid) begin ok = 1; break; end
      end
      mem_res_valid = 0;
      step();
      @(negedge clk);
      chk("drain_done", 32'(ok && grant == 2'd0), 32'd1);
   endtask

   initial begin
      rst = 1;
      if_req_valid = 0; if_req_addr = 0;
      d_read_req_valid = 0; d_read_req_addr = 0;
      d_write_req_valid = 0; d_write_req_addr = 0; d_write_req_data = 0; d_write_req_mask = 0;
      mem_res_valid = 0; mem_res_rdata = 0;
      step(); step();
      rst = 0;
      chk_en = 1;
      @(negedge clk);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
      chk("rst_mem_req_addr", mem_req_addr, 32'd0);
      chk("rst_mem_req_wdata", mem_req_wdata, 32'd0);
      chk("rst_mem_req_mask_write", {27'd0, mem_req_mask, mem_req_write}, 32'd0);
      chk("rst_res_valids", {29'd0, if_res_valid, d_read_res_valid, d_write_res_valid}, 32'd0);

      // Single fetch, memory answers in the second BUSY cycle.
      step(); if_req_valid = 1; if_req_addr = 32'h100;
      @(negedge clk); chk("t1_idle_grant", 32'(grant), 32'd0);
      step();
      @(negedge clk);
      chk("t1_grant", 32'(grant), 32'd1);
      chk("t1_mrv", 32'(mem_req_valid), 32'd1);
      chk("t1_addr", mem_req_addr, 32'h100);
      chk("t1_mask_write", {27'd0, mem_req_mask, mem_req_write}, {27'd0, 4'hF, 1'b0});
      step(); mem_res_valid = 1; mem_res_rdata = 32'hDEADBEEF;
      @(negedge clk);
      chk("t1_res_valid", 32'(if_res_valid), 32'd1);
      chk("t1_res_data", if_res_data, 32'hDEADBEEF);
      step(); mem_res_valid = 0; if_req_valid = 0;
      @(negedge clk);
      chk("t1_end_grant", 32'(grant), 32'd0);
      chk("t1_end_res", 32'(if_res_valid), 32'd0);

      // All three at once: write, then read, then fetch.
      gq.delete(); mq.delete(); aq.delete(); sq.delete();
      cnt[1] = 0; cnt[2] = 0; cnt[3] = 0;
      step();
      d_write_req_valid = 1; d_write_req_addr = 32'h200; d_write_req_data = 32'h11223344;
      d_write_req_mask = 4'b0011;
      d_read_req_valid = 1; d_read_req_addr = 32'h204;
      if_req_valid = 1; if_req_addr = 32'h104;
      run(12, 0, 0, 100, 0, 0, 0, 4'b0);
      drain();
      chk("t2_ngrants", 32'(gq.size()), 32'd3);
      if (gq.size() == 3) begin
         chk("t2_order0", 32'(gq[0]), 32'd3);
         chk("t2_order1", 32'(gq[1]), 32'd2);
         chk("t2_order2", 32'(gq[2]), 32'd1);
         chk("t2_wr_mask", 32'(mq[0]), 32'h3);
         chk("t2_addr0", 32'(aq[0]), 32'h200);
         chk("t2_addr1", 32'(aq[1]), 32'h204);
         chk("t2_addr2", 32'(aq[2]), 32'h104);
      end
      chk("t2_pulses", {cnt[1][7:0], cnt[2][7:0], cnt[3][7:0]}, {8'd1, 8'd1, 8'd1});

      // Starvation: reads re-request back-to-back while fetch waits.
      gq.delete(); sq.delete();
      step();
      if_req_valid = 1; if_req_addr = 32'h300;
      d_read_req_valid = 1; d_read_req_addr = 32'h400;
      run(12, 0, 0, 100, 0, 0, 0, 4'b0100);
      drain();
      chk("t3_ngrants", 32'(gq.size() >= 5), 32'd1);
      if (gq.size() >= 5) begin
         for (int i = 0; i < 4; i++) chk($sformatf("t3_data_grant%0d", i), 32'(gq[i]), 32'd2);
         chk("t3_fetch_grant", 32'(gq[4]), 32'd1);
         chk("t3_starve_at_max", 32'(sq[3]), 32'd4);
         chk("t3_starve_cleared", 32'(sq[4]), 32'd0);
      end

      // Zero-wait memory with a write.
      step();
      d_write_req_valid = 1; d_write_req_addr = 32'h500; d_write_req_data = 32'hCAFEF00D;
      d_write_req_mask = 4'b1000; mem_res_valid = 1;
      @(negedge clk);
      chk("t4_idle_grant", 32'(grant), 32'd0);
      chk("t4_idle_no_res", 32'(d_write_res_valid), 32'd0);
      step();
      @(negedge clk);
      chk("t4_grant", 32'(grant), 32'd3);
      chk("t4_res", 32'(d_write_res_valid), 32'd1);
      chk("t4_wdata", mem_req_wdata, 32'hCAFEF00D);
      step(); d_write_req_valid = 0; mem_res_valid = 0;
      @(negedge clk);
      chk("t4_back_idle", {30'd0, grant}, 32'd0);
      chk("t4_mrv_low", 32'(mem_req_valid), 32'd0);

      // Owner drops its valid mid-BUSY.
      step(); d_read_req_valid = 1; d_read_req_addr = 32'h600;
      step();
      @(negedge clk); chk("t5_grant", 32'(grant), 32'd2);
      step(); d_read_req_valid = 0;
      @(negedge clk);
      chk("t5_still_busy", 32'(mem_req_valid), 32'd1);
      chk("t5_addr", mem_req_addr, 32'h600);
      step(); mem_res_valid = 1; mem_res_rdata = 32'h55AA55AA;
      @(negedge clk);
      chk("t5_res", 32'(d_read_res_valid), 32'd1);
      chk("t5_data", d_read_res_data, 32'h55AA55AA);
      step(); mem_res_valid = 0;
      @(negedge clk); chk("t5_idle", 32'(grant), 32'd0);

      // Reset mid-BUSY, then a stray response in IDLE.
      step(); if_req_valid = 1; if_req_addr = 32'h700;
      step();
      @(negedge clk); chk("t6_grant", 32'(grant), 32'd1);
      step(); rst = 1; if_req_valid = 0;
      step(); rst = 0;
      @(negedge clk);
      chk("t6_mrv_after_rst", 32'(mem_req_valid), 32'd0);
      chk("t6_grant_after_rst", 32'(grant), 32'd0);
      step(); mem_res_valid = 1; mem_res_rdata = 32'h12345678;
      @(negedge clk);
      chk("t6_no_stray_res", {29'd0, if_res_valid, d_read_res_valid, d_write_res_valid}, 32'd0);
      step(); mem_res_valid = 0;

      // Random traffic with stray responses, owner drops and occasional resets.
      run(3000, 30, 30, 40, 3, 5, 20, 4'b0);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
